// File: rtl/approx_mul_ha_pipe_if.sv
// Operand/product stream bundle for the approximate multiplier.
// slave = multiplier side, master = the block feeding operands and taking products.
interface approx_mul_ha_pipe_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           exact_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  modport slave (
    input  in_valid, x, y, exact_mode, out_ready,
    output in_ready, out_valid, p
  );

  modport master (
    output in_valid, x, y, exact_mode, out_ready,
    input  in_ready, out_valid, p
  );
endinterface

// File: rtl/approx_mul_ha_pipe.sv
// Three-stage WxW approximate multiplier: paired partial-product rows, half-adder/OR compression, exact final add.
// Optional error statistics are built when APPROX_ERR_STAT_EN is defined.
module approx_mul_ha_pipe #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_mul_ha_pipe_if.slave bus
`ifdef APPROX_ERR_STAT_EN
  ,
  input  logic                err_clr,
  output logic [2*W+15:0]     err_sum,
  output logic [2*W-1:0]      err_max,
  output logic [31:0]         beat_cnt
`endif
);

  localparam int NP = W / 2;

  logic                 v1, v2, v3;
  logic [W-1:0]         x1, y1;
  logic                 e1;
  logic [NP-1:0][W:0]   sr2, cr2;
  logic [NP-1:0][W:0]   sr_c, cr_c;
  logic [2*W-1:0]       p3, acc_c;
  logic                 adv;

  // No bubble collapse: the whole pipe stalls only when the output is held.
  assign adv           = !v3 | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;
  assign bus.p         = p3;

  always_comb begin
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    for (int k = 0; k < NP; k++) begin
      sr_c[k]    = '0;
      cr_c[k]    = '0;
      sr_c[k][0] = x1[2*k] & y1[0];
      sr_c[k][W] = x1[2*k+1] & y1[W-1];
      for (int j = 1; j < W; j++) begin
        a = x1[2*k] & y1[j];
        b = x1[2*k+1] & y1[j-1];
        // OR-sum with dropped carry can only under-estimate, keeping error non-negative.
        if ((2*k + j) < APPROX_COLS && !e1) begin
          sr_c[k][j] = a | b;
        end else begin
          sr_c[k][j]   = a ^ b;
          cr_c[k][j+1] = a & b;
        end
      end
    end
  end

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < NP; k++) begin
      acc_c = acc_c + (((2*W)'(sr2[k]) + (2*W)'(cr2[k])) << (2*k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      x1  <= '0;
      y1  <= '0;
      e1  <= 1'b0;
      sr2 <= '0;
      cr2 <= '0;
      p3  <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      if (bus.in_valid) begin
        x1 <= bus.x;
        y1 <= bus.y;
        e1 <= bus.exact_mode;
      end
      if (v1) begin
        sr2 <= sr_c;
        cr2 <= cr_c;
      end
      if (v2) begin
        p3 <= acc_c;
      end
    end
  end

`ifdef APPROX_ERR_STAT_EN
  logic [2*W-1:0] ex2, ex3, err;
  logic [2*W+16:0] sum_nx;
  logic            fire;

  assign fire   = v3 & bus.out_ready;
  assign err    = ex3 - p3;
  assign sum_nx = {1'b0, err_sum} + (2*W+17)'(err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex2 <= '0;
      ex3 <= '0;
    end else if (adv) begin
      if (v1) ex2 <= (2*W)'(x1) * (2*W)'(y1);
      if (v2) ex3 <= ex2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum  <= '0;
      err_max  <= '0;
      beat_cnt <= '0;
    end else if (err_clr) begin
      err_sum  <= '0;
      err_max  <= '0;
      beat_cnt <= '0;
    end else if (fire) begin
      err_sum <= sum_nx[2*W+16] ? '1 : sum_nx[2*W+15:0];
      if (err > err_max) err_max <= err;
      if (beat_cnt != '1) beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Directed bench: one exact instance (APPROX_COLS=0) and one fully approximate instance (APPROX_COLS=16), W=8.
// Define APPROX_ERR_STAT_EN to also exercise the error statistics.
module tb_approx_mul_ha_pipe;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  approx_mul_ha_pipe_if #(.W(8)) ifc_e ();
  approx_mul_ha_pipe_if #(.W(8)) ifc_a ();

`ifdef APPROX_ERR_STAT_EN
  logic        clr_e, clr_a;
  logic [31:0] sum_e, sum_a, cnt_e, cnt_a;
  logic [15:0] max_e, max_a;
`endif

  approx_mul_ha_pipe #(.W(8), .APPROX_COLS(0)) u_exact (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc_e)
`ifdef APPROX_ERR_STAT_EN
    ,
    .err_clr  (clr_e),
    .err_sum  (sum_e),
    .err_max  (max_e),
    .beat_cnt (cnt_e)
`endif
  );

  approx_mul_ha_pipe #(.W(8), .APPROX_COLS(16)) u_apx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc_a)
`ifdef APPROX_ERR_STAT_EN
    ,
    .err_clr  (clr_a),
    .err_sum  (sum_a),
    .err_max  (max_a),
    .beat_cnt (cnt_a)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] xv, input logic [7:0] yv, input logic ev);
    ifc_e.in_valid = v;  ifc_e.x = xv;  ifc_e.y = yv;  ifc_e.exact_mode = ev;
    ifc_a.in_valid = v;  ifc_a.x = xv;  ifc_a.y = yv;  ifc_a.exact_mode = ev;
  endtask

  task automatic set_ready(input logic r);
    ifc_e.out_ready = r;
    ifc_a.out_ready = r;
  endtask

  // Single beat through an idle pipe with out_ready=1; returns both products.
  task automatic run_one(input logic [7:0] xv, input logic [7:0] yv, input logic ev,
                         output logic [15:0] pe, output logic [15:0] pa);
    drive(1'b1, xv, yv, ev);
    step();
    drive(1'b0, xv, yv, ev);
    step();
    step();
    chk("one_valid_e", ifc_e.out_valid, 1);
    chk("one_valid_a", ifc_a.out_valid, 1);
    pe = ifc_e.p;
    pa = ifc_a.p;
    step();
  endtask

  typedef struct {
    logic [7:0] xv;
    logic [7:0] yv;
    logic       ev;
    logic [15:0] exp_a;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] pe, pa, prod;
    logic [15:0] q_prod[$];
    logic        q_mode[$];
    logic        stale;
    int          n_out;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    set_ready(1'b1);
`ifdef APPROX_ERR_STAT_EN
    clr_e = 1'b0;
    clr_a = 1'b0;
`endif
    #12;
    chk("rst_out_valid_e", ifc_e.out_valid, 0);
    chk("rst_out_valid_a", ifc_a.out_valid, 0);
    chk("rst_p_e", ifc_e.p, 0);
    chk("rst_p_a", ifc_a.p, 0);
    chk("rst_in_ready", ifc_e.in_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // Latency: accepted on edge 0, visible after edge 2.
    drive(1'b1, 8'd255, 8'd255, 1'b0);
    step();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    chk("lat_c1_valid", ifc_e.out_valid, 0);
    step();
    chk("lat_c2_valid", ifc_e.out_valid, 0);
    step();
    chk("lat_c3_valid", ifc_e.out_valid, 1);
    chk("lat_c3_p", ifc_e.p, 65025);
    chk("lat_apx_le", ifc_a.p <= 16'd65025, 1);
    step();
    chk("lat_handoff", ifc_e.out_valid, 0);

    // Hand-computed approximate products with every column approximate.
    vecs.push_back('{8'd3,   8'd3,   1'b0, 16'd7});
    vecs.push_back('{8'd3,   8'd3,   1'b1, 16'd9});
    vecs.push_back('{8'd3,   8'd7,   1'b0, 16'd15});
    vecs.push_back('{8'd15,  8'd3,   1'b0, 16'd35});
    vecs.push_back('{8'd1,   8'd255, 1'b0, 16'd255});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 16'd0});
    vecs.push_back('{8'd255, 8'd0,   1'b0, 16'd0});
    vecs.push_back('{8'd0,   8'd77,  1'b1, 16'd0});
    vecs.push_back('{8'd15,  8'd3,   1'b1, 16'd45});
    foreach (vecs[i]) begin
      run_one(vecs[i].xv, vecs[i].yv, vecs[i].ev, pe, pa);
      prod = 16'(vecs[i].xv) * 16'(vecs[i].yv);
      chk("vec_exact", pe, prod);
      chk("vec_apx", pa, vecs[i].exp_a);
    end

    // Backpressure: three beats fill the pipe, the fourth waits.
    set_ready(1'b0);
    drive(1'b1, 8'd1, 8'd2, 1'b0);
    chk("bp_ready0", ifc_e.in_ready, 1);
    step();
    drive(1'b1, 8'd2, 8'd2, 1'b0);
    step();
    drive(1'b1, 8'd3, 8'd2, 1'b0);
    step();
    drive(1'b1, 8'd4, 8'd2, 1'b0);
    chk("bp_full_ready_e", ifc_e.in_ready, 0);
    chk("bp_full_ready_a", ifc_a.in_ready, 0);
    step();
    step();
    chk("bp_hold_valid", ifc_e.out_valid, 1);
    chk("bp_hold_p", ifc_e.p, 2);
    set_ready(1'b1);
    step();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    chk("bp_p4", ifc_e.p, 4);
    chk("bp_p4_a", ifc_a.p, 4);
    step();
    chk("bp_p6", ifc_e.p, 6);
    chk("bp_p6_a", ifc_a.p, 6);
    step();
    chk("bp_p8_valid", ifc_e.out_valid, 1);
    chk("bp_p8", ifc_e.p, 8);
    chk("bp_p8_a", ifc_a.p, 8);
    step();
    chk("bp_drained", ifc_e.out_valid, 0);

    // Streaming at one beat per cycle.
    n_out = 0;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        logic [7:0] xr, yr;
        logic       er;
        xr = 8'($urandom_range(0, 255));
        yr = 8'($urandom_range(0, 255));
        er = 1'($urandom_range(0, 1));
        drive(1'b1, xr, yr, er);
        q_prod.push_back(16'(xr) * 16'(yr));
        q_mode.push_back(er);
      end else begin
        drive(1'b0, 8'd0, 8'd0, 1'b0);
      end
      step();
      chk("stream_valid", ifc_e.out_valid, (i >= 2) ? 1 : 0);
      if (ifc_e.out_valid && q_prod.size() > 0) begin
        logic [15:0] exp_p;
        logic        m;
        exp_p = q_prod.pop_front();
        m     = q_mode.pop_front();
        n_out++;
        chk("stream_exact", ifc_e.p, exp_p);
        if (m) chk("stream_apx_exactmode", ifc_a.p, exp_p);
        else   chk("stream_apx_le", ifc_a.p <= exp_p, 1);
      end
    end
    step();
    chk("stream_count", n_out, 100);
    chk("stream_idle", ifc_e.out_valid, 0);

    // Reset with beats in flight, output held.
    set_ready(1'b0);
    drive(1'b1, 8'd5, 8'd5, 1'b0);
    step();
    drive(1'b1, 8'd6, 8'd6, 1'b0);
    step();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    step();
    chk("rmid_pre_valid", ifc_e.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_valid_e", ifc_e.out_valid, 0);
    chk("rmid_valid_a", ifc_a.out_valid, 0);
    chk("rmid_p", ifc_e.p, 0);
    step();
    rst_n = 1'b1;
    set_ready(1'b1);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      stale = stale | ifc_e.out_valid | ifc_a.out_valid;
    end
    chk("rmid_no_stale", stale, 0);

`ifdef APPROX_ERR_STAT_EN
    chk("stat_rst_sum", sum_a, 0);
    chk("stat_rst_cnt", cnt_a, 0);
    run_one(8'd3, 8'd3, 1'b0, pe, pa);
    run_one(8'd3, 8'd3, 1'b0, pe, pa);
    chk("stat_sum", sum_a, 4);
    chk("stat_max", max_a, 2);
    chk("stat_cnt", cnt_a, 2);
    chk("stat_exact_sum", sum_e, 0);
    chk("stat_exact_cnt", cnt_e, 2);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("stat_clr_sum", sum_a, 0);
    chk("stat_clr_max", max_a, 0);
    chk("stat_clr_cnt", cnt_a, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
